// File: rtl/skid_register.sv
`default_nettype none
// ============================================================================
// Module   : skid_register
// Purpose  : Two-entry valid/ready skid buffer. Upstream ready is driven from
//            a flop, so it never depends on downstream ready combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module skid_register #(
   parameter int WIDTH = 64
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid_AS,
   output logic             oReady_AS,
   input  logic [WIDTH-1:0] iData_AS,
   output logic             oValid_BM,
   input  logic             iReady_BM,
   output logic [WIDTH-1:0] oData_BM,
   output logic [1:0]       oCount
);

   // State encoding doubles as the occupancy count.
   localparam logic [1:0] c_empty = 2'd0;
   localparam logic [1:0] c_half  = 2'd1;
   localparam logic [1:0] c_full  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] main_q,  main_d;
   logic [WIDTH-1:0] skid_q,  skid_d;
   logic             ready_q, ready_d;
   logic             w_accept;
   logic             w_pop;
   logic             w_valid;

   // State register
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= c_empty;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   // Next-state and storage update
   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      w_accept = iValid_AS && ready_q;
      w_pop    = w_valid && iReady_BM;
      case (state_q)
         c_empty: begin
            if (w_accept) begin
               main_d  = iData_AS;
               state_d = c_half;
            end
         end
         c_half: begin
            if (w_accept && w_pop) begin
               main_d = iData_AS;
            end else if (w_accept) begin
               skid_d  = iData_AS;
               state_d = c_full;
            end else if (w_pop) begin
               state_d = c_empty;
            end
         end
         c_full: begin
            if (w_pop) begin
               main_d  = skid_q;
               state_d = c_half;
            end
         end
         default: state_d = c_empty;
      endcase
      // Ready is registered from the next state so it is a flop output.
      ready_d = (state_d != c_full);
   end

   // Outputs depend only on registered state
   always_comb begin
      w_valid   = (state_q == c_half) || (state_q == c_full);
      oValid_BM = w_valid;
      oReady_AS = ready_q;
      oData_BM  = main_q;
      oCount    = state_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_skid_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_register
// Purpose  : Self-checking bench for skid_register against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid_register;

   localparam int WIDTH = 64;

   logic             clk;
   logic             rst;
   logic             valid_as;
   logic             ready_as;
   logic [WIDTH-1:0] data_as;
   logic             valid_bm;
   logic             ready_bm;
   logic [WIDTH-1:0] data_bm;
   logic [1:0]       count;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: the buffer is just a FIFO of at most two words.
   logic [WIDTH-1:0] model_q[$];
   logic             exp_ready;
   logic             exp_zero_data;
   logic             last_acc;

   skid_register #(.WIDTH(WIDTH)) u_dut (
      .iCLK      (clk),
      .iRST      (rst),
      .iValid_AS (valid_as),
      .oReady_AS (ready_as),
      .iData_AS  (data_as),
      .oValid_BM (valid_bm),
      .iReady_BM (ready_bm),
      .oData_BM  (data_bm),
      .oCount    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic rdy);
      logic acc;
      logic pp;
      rst      = r;
      valid_as = v;
      data_as  = d;
      ready_bm = rdy;
      @(posedge clk);
      if (r) begin
         model_q.delete();
         exp_ready     = 1'b0;
         exp_zero_data = 1'b1;
         last_acc      = 1'b0;
      end else begin
         acc = v && exp_ready;
         pp  = (model_q.size() > 0) && rdy;
         if (pp) void'(model_q.pop_front());
         if (acc) begin
            model_q.push_back(d);
            exp_zero_data = 1'b0;
         end
         exp_ready = (model_q.size() < 2);
         last_acc  = acc;
      end
      @(negedge clk);
      check("valid", {63'd0, valid_bm}, {63'd0, model_q.size() > 0});
      check("ready", {63'd0, ready_as}, {63'd0, exp_ready});
      check("count", {62'd0, count}, WIDTH'(model_q.size()));
      if (model_q.size() > 0)
         check("data", data_bm, model_q[0]);
      else if (exp_zero_data)
         check("data_rst", data_bm, '0);
   endtask

   // Offer a word until it is accepted, with a bounded wait.
   task automatic send(input logic [WIDTH-1:0] d, input logic rdy);
      int tries = 0;
      do begin
         cycle(1'b0, 1'b1, d, rdy);
         tries++;
      end while (!last_acc && tries < 50);
      check("send_timeout", {63'd0, last_acc}, 64'd1);
   endtask

   initial begin
      int accepted;
      int guard;
      rst = 1'b1; valid_as = 1'b0; data_as = '0; ready_bm = 1'b0;
      exp_ready = 1'b0; exp_zero_data = 1'b1; last_acc = 1'b0;

      // Reset with active handshakes
      repeat (3) cycle(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      check("ready_after_rst", {63'd0, ready_as}, 64'd1);

      // Single word
      send(64'h0000_0001_0000_0002, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);

      // Streaming 0..15
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, WIDTH'(i), 1'b1);
      repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);

      // Backpressure fill, then release
      send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      send(64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
      repeat (2) cycle(1'b0, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0);
      check("full_count", {62'd0, count}, 64'd2);
      send(64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);

      // Random stalls on both sides
      accepted = 0;
      guard    = 0;
      while (accepted < 1000 && guard < 20000) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         if (last_acc) accepted++;
         guard++;
      end
      check("random_budget", WIDTH'(accepted), 64'd1000);
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);

      // Reset while full: buffered words are discarded
      send(64'h1111_1111_1111_1111, 1'b0);
      send(64'h2222_2222_2222_2222, 1'b0);
      check("prefull_count", {62'd0, count}, 64'd2);
      cycle(1'b1, 1'b0, '0, 1'b1);
      check("rst_full_count", {62'd0, count}, 64'd0);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/skid_register.md
Name: skid_register

Overview:
- Two-entry elastic pipeline register (skid buffer) on the valid/ready stream fabric.
- Placed directly downstream of the two-input stream combiner. It consumes the concatenated stream and re-times it for the next stage.
- Breaks the combinational ready path: the upstream ready is driven from a flop and never depends on iReady_BM in the same cycle.
- Sustains one transfer per cycle under continuous flow. Data order and content are preserved bit-exact.

Parameters:
WIDTH, 64, data width in bits (default matches two 32-bit combined operands)

Ports:
iCLK  input  1  clock; all state updates on rising edge
iRST  input  1  reset, synchronous, active-high
iValid_AS  input  1  upstream data valid
oReady_AS  output  1  upstream ready (registered)
iData_AS  input  WIDTH  upstream data
oValid_BM  output  1  downstream data valid (registered)
iReady_BM  input  1  downstream ready
oData_BM  output  WIDTH  downstream data (registered)
oCount  output  2  occupancy, 0..2 (registered, status only)

Behaviour:
- Handshake definitions:
  - accept = iValid_AS && oReady_AS
  - pop = oValid_BM && iReady_BM
  - A transfer occurs on the rising edge where the respective term is 1.
- Storage: main register (drives oData_BM) and skid register.
- States, encoded by oCount:
  - EMPTY (0): main empty, skid empty
  - HALF (1): main full, skid empty
  - FULL (2): main full, skid full
- Outputs per state:
  - oValid_BM = 1 in HALF and FULL, 0 in EMPTY.
  - oReady_AS = 1 in EMPTY and HALF, 0 in FULL.
  - Both are pure functions of the registered state; there is no combinational path from iReady_BM or iValid_AS to any output.
- Transitions from EMPTY:
  - accept: main <= iData_AS, go to HALF.
  - Otherwise stay; pop cannot occur.
- Transitions from HALF:
  - accept && pop: main <= iData_AS, stay in HALF.
  - accept && !pop: skid <= iData_AS, go to FULL.
  - !accept && pop: go to EMPTY.
  - Neither: hold.
- Transitions from FULL:
  - accept cannot occur (oReady_AS = 0).
  - pop: main <= skid, go to HALF.
  - Otherwise hold.
- Latency: 1 cycle. Data accepted at edge N is visible on oData_BM with oValid_BM = 1 from edge N onward (i.e. in cycle N+1) when the buffer was EMPTY.
- Throughput: 1 word/cycle while iValid_AS and iReady_BM are both held high. The block stays in HALF with no bubbles.
- Ordering: strict FIFO; the skid word is always emitted after the main word.
- Data stability: oData_BM and oValid_BM must not change while oValid_BM = 1 and iReady_BM = 0. iData_AS is ignored when accept = 0.
- Reset, on any edge with iRST = 1 (regardless of state or in-flight handshakes):
  - state EMPTY, oCount = 0
  - oValid_BM = 0, oData_BM = 0, skid register = 0
  - oReady_AS = 0 while iRST is high
  - oReady_AS = 1 from the first edge with iRST = 0
- Reset mid-operation: buffered words are discarded. No pop is reported on the reset edge even if iReady_BM = 1.
- Downstream ready toggling in FULL: only one word is released per pop. oReady_AS rises the cycle after the pop edge.
- Width rules: no arithmetic; data passes unchanged at WIDTH bits. oCount saturates by construction (never 3).

Test Plan:
- Reset then idle: assert iRST 3 cycles with iValid_AS = 1, iReady_BM = 1 -> oValid_BM = 0, oReady_AS = 0, oCount = 0, oData_BM = 0. One cycle after iRST falls: oReady_AS = 1.
- Single word: send 0x0000_0001_0000_0002 with iReady_BM = 1 -> oValid_BM high for exactly 1 cycle, starting the cycle after accept, carrying that value; oCount goes 0->1->0.
- Streaming: iValid_AS = 1 for 16 cycles with an incrementing pattern 0..15, iReady_BM = 1 -> 16 consecutive pops with values 0..15 in order; oCount stays 1 after the first word; oReady_AS never drops.
- Backpressure fill: iReady_BM = 0, offer A, B, C -> A and B accepted, oCount = 2, oReady_AS = 0, C held upstream. Release iReady_BM -> output A, B, C in order; oReady_AS returns to 1 the cycle after the first pop.
- Random stall: 1000 words, iValid_AS and iReady_BM each random at 50% -> scoreboard shows no loss, duplication or reorder. oData_BM is stable whenever oValid_BM = 1 and iReady_BM = 0; no combinational ready path exists.
- Reset mid-FULL: fill to oCount = 2, assert iRST for one cycle with iReady_BM = 1 -> next cycle oCount = 0, oValid_BM = 0. Neither buffered word ever appears on the output.
